// File: rtl/cache_line_memory.sv
// rtl/cache_line_memory.sv - main-memory responder for the direct-mapped cache
//
// Serves line-fill reads and line write-backs. A read returns a 2048-bit line
// as eight 256-bit beats after LATENCY cycles. A write-back is stored and then
// acknowledged with a single zero beat.
//
// Only 2^STORE_LOG2 line slots are backed by real storage. Each slot keeps the
// full 24-bit line address as its tag. A read that misses the stored tag
// returns a synthetic pattern line: byte j = addr[7:0] + j (mod 256).
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_write             1 = write-back, 0 = line fill
//   req_addr[23:0]        line address (physical address bits [31:8])
//   req_wdata[2047:0]     write-back line, byte j at bits [8j+7:8j]
//   rsp_valid/rsp_ready   response beat handshake
//   rsp_data[255:0]       beat k = line bits [256k+255:256k]; zero for write ack
//   rsp_last              final beat of the response
module cache_line_memory #(
  parameter int LATENCY    = 4,
  parameter int STORE_LOG2 = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [23:0]   req_addr,
  input  logic [2047:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [255:0]  rsp_data,
  output logic          rsp_last
);

  localparam int SLOTS = 1 << STORE_LOG2;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND,
    WACK
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [2:0]             beat;
  logic [23:0]            cap_addr;
  logic                   cap_write;

  logic [2047:0]          mem_data [SLOTS];
  logic [23:0]            mem_tag  [SLOTS];
  logic [SLOTS-1:0]       mem_valid;

  logic                   accept;
  logic [STORE_LOG2-1:0]  req_slot;
  logic [STORE_LOG2-1:0]  cap_slot;
  logic [2:0]             beat_sel;
  logic [2047:0]          slot_line;
  logic                   hit;
  logic [255:0]           beat_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_slot  = req_addr[STORE_LOG2-1:0];
  assign cap_slot  = cap_addr[STORE_LOG2-1:0];

  // beat_data is the beat that will be registered onto rsp_data at the next
  // edge: beat 0 when leaving WAIT, otherwise the beat after the current one.
  // Storage cannot change while a transaction is in flight, so reading the
  // slot here gives the same line as reading it at acceptance.
  always_comb begin
    beat_sel  = (state == SEND) ? beat + 3'd1 : 3'd0;
    slot_line = mem_data[cap_slot];
    hit       = mem_valid[cap_slot] && (mem_tag[cap_slot] == cap_addr);
    beat_data = '0;
    if (hit) begin
      beat_data = slot_line[{beat_sel, 8'd0} +: 256];
    end else begin
      for (int i = 0; i < 32; i++) begin
        beat_data[8*i +: 8] = cap_addr[7:0] + {beat_sel, 5'(i)};
      end
    end
  end

  // Line storage is committed on the accepting edge. The data and tag arrays
  // need no reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (!reset && accept && req_write) begin
      mem_data[req_slot] <= req_wdata;
      mem_tag[req_slot]  <= req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      beat      <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      mem_valid <= '0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_addr  <= req_addr;
            cap_write <= req_write;
            cnt       <= '0;
            state     <= WAIT;
            if (req_write) begin
              mem_valid[req_slot] <= 1'b1;
            end
          end
        end

        WAIT: begin
          if (cnt == CW'(LATENCY - 1)) begin
            rsp_valid <= 1'b1;
            if (cap_write) begin
              state    <= WACK;
              rsp_last <= 1'b1;
              rsp_data <= '0;
            end else begin
              state    <= SEND;
              beat     <= '0;
              rsp_last <= 1'b0;
              rsp_data <= beat_data;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SEND: begin
          if (rsp_ready) begin
            if (beat == 3'd7) begin
              state     <= IDLE;
              beat      <= '0;
              rsp_valid <= 1'b0;
              rsp_last  <= 1'b0;
              rsp_data  <= '0;
            end else begin
              beat     <= beat + 3'd1;
              rsp_data <= beat_data;
              rsp_last <= (beat == 3'd6);
            end
          end
        end

        WACK: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_memory.sv
// tb/tb_cache_line_memory.sv - scoreboard bench for cache_line_memory
module tb_cache_line_memory;

  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [23:0]   req_addr;
  logic [2047:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [255:0]  rsp_data;
  logic          rsp_last;

  cache_line_memory #(.LATENCY(LAT), .STORE_LOG2(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] data;
    logic         last;
  } beat_t;

  beat_t         exp_q [$];
  logic [2047:0] model_line [int];

  int   passed = 0;
  int   total = 0;
  int   hs_count = 0;
  int   vcount = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  int   rdy_phase = 0;
  logic stall_prev = 1'b0;
  logic [255:0] prev_data;
  logic prev_last;

  task automatic chk(input string name, input logic ok, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s got=%h exp=%h", name, act, exp);
  endtask

  function automatic logic [2047:0] pattern(input logic [23:0] a);
    logic [2047:0] p;
    for (int j = 0; j < 256; j++) p[8*j +: 8] = a[7:0] + 8'(j);
    return p;
  endfunction

  // Reference model: address -> line map where a write evicts any other line
  // sharing the low four address bits.
  task automatic model_push(input logic w, input logic [23:0] a, input logic [2047:0] d);
    int victims [$];
    logic [2047:0] line;
    beat_t b;
    if (w) begin
      foreach (model_line[k]) if ((k & 15) == (int'(a) & 15)) victims.push_back(k);
      foreach (victims[i]) model_line.delete(victims[i]);
      model_line[int'(a)] = d;
      b.data = '0;
      b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      line = model_line.exists(int'(a)) ? model_line[int'(a)] : pattern(a);
      for (int k = 0; k < 8; k++) begin
        b.data = line[256*k +: 256];
        b.last = (k == 7);
        exp_q.push_back(b);
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: rsp_ready = 1'b1;
      1: begin rsp_ready = (rdy_phase % 3 == 0); rdy_phase++; end
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: inputs only change just after posedges, so values seen at the
  // negedge are exactly what the next posedge will sample.
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (rsp_valid) vcount++;
      if (stall_prev)
        chk("stall_hold", rsp_valid && rsp_data == prev_data && rsp_last == prev_last,
            {rsp_valid, rsp_last, rsp_data[253:0]}, {1'b1, prev_last, prev_data[253:0]});
      if (rsp_valid && rsp_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1'b0, rsp_data, '0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", rsp_data == e.data, rsp_data, e.data);
          chk("beat_last", rsp_last == e.last, 256'(rsp_last), 256'(e.last));
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_last  = rsp_last;
    end
  end

  // Returns at the accepting edge + 1 time unit, with acc_cyc = that edge.
  task automatic do_req(input logic w, input logic [23:0] a, input logic [2047:0] d, output int acc_cyc);
    logic acc = 1'b0;
    int n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = req_ready && !reset;
      if (acc) model_push(w, a, d);
      @(posedge clk);
      n++;
    end
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    if (!acc) chk("accept_timeout", 1'b0, 256'(n), 256'(0));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(exp_q.size() == 0 && req_ready && !rsp_valid) && n < 500);
    if (n >= 500) chk("idle_timeout", 1'b0, 256'(exp_q.size()), 256'(0));
  endtask

  function automatic logic [2047:0] fill(input logic [7:0] b);
    logic [2047:0] l;
    for (int j = 0; j < 256; j++) l[8*j +: 8] = b;
    return l;
  endfunction

  initial begin
    int e, e2, h0, n, v0;
    logic [2047:0] d;
    logic [23:0] a;
    logic w;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_rsp_valid", !rsp_valid, 256'(rsp_valid), 256'(0));
    chk("reset_rsp_last", !rsp_last, 256'(rsp_last), 256'(0));
    chk("reset_rsp_data", rsp_data == '0, rsp_data, '0);
    chk("reset_req_ready", req_ready, 256'(req_ready), 256'(1));

    // Pattern read with exact latency and handshake timing.
    ready_mode = 0;
    do_req(1'b0, 24'h0001FE, '0, e);
    repeat (LAT - 1) @(posedge clk);
    #1 chk("lat_early", !rsp_valid, 256'(rsp_valid), 256'(0));
    @(posedge clk);
    #1 chk("lat_first", rsp_valid, 256'(rsp_valid), 256'(1));
    chk("beat0_bytes", rsp_data[31:0] == 32'h0100FFFE, 256'(rsp_data[31:0]), 256'(32'h0100FFFE));
    chk("beat0_notlast", !rsp_last, 256'(rsp_last), 256'(0));
    repeat (7) @(posedge clk);
    #1 chk("beat7_last", rsp_last && !req_ready, {rsp_last, req_ready}, 2'b10);
    @(posedge clk);
    #1 chk("ready_after", req_ready && !rsp_valid, {req_ready, rsp_valid}, 2'b10);
    wait_idle();

    // Backpressure 1,0,0,...
    ready_mode = 1; rdy_phase = 1;
    h0 = hs_count;
    do_req(1'b0, 24'h0001FE, '0, e);
    wait_idle();
    chk("bp_handshakes", hs_count - h0 == 8, 256'(hs_count - h0), 256'(8));
    ready_mode = 0;

    // Write-back then read.
    do_req(1'b1, 24'h000010, fill(8'hA5), e);
    repeat (LAT - 1) @(posedge clk);
    #1 chk("wack_early", !rsp_valid, 256'(rsp_valid), 256'(0));
    @(posedge clk);
    #1 chk("wack_beat", rsp_valid && rsp_last && rsp_data == '0, {rsp_valid, rsp_last}, 2'b11);
    wait_idle();
    do_req(1'b0, 24'h000010, '0, e);
    wait_idle();

    // Aliasing.
    do_req(1'b0, 24'h010010, '0, e);
    wait_idle();
    do_req(1'b1, 24'h010010, fill(8'h3C), e);
    wait_idle();
    do_req(1'b0, 24'h000010, '0, e);
    wait_idle();

    // Reset mid-SEND after beat 3 handshakes.
    do_req(1'b1, 24'h000010, fill(8'hA5), e);
    wait_idle();
    h0 = hs_count;
    do_req(1'b0, 24'h000010, '0, e);
    n = 0;
    while (hs_count < h0 + 4 && n < 100) begin @(posedge clk); n++; end
    if (n >= 100) chk("midsend_timeout", 1'b0, 256'(hs_count - h0), 256'(4));
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_valid", !rsp_valid, 256'(rsp_valid), 256'(0));
    chk("abort_ready", req_ready, 256'(req_ready), 256'(1));
    exp_q.delete();
    model_line.delete();
    do_req(1'b0, 24'h000010, '0, e);
    wait_idle();

    // Busy: second request held until the first completes.
    do_req(1'b0, 24'h000123, '0, e);
    chk("busy_ready_low", !req_ready, 256'(req_ready), 256'(0));
    do_req(1'b0, 24'h000045, '0, e2);
    chk("busy_accept_cycle", e2 == e + LAT + 9, 256'(e2), 256'(e + LAT + 9));
    wait_idle();

    // Requests during reset are ignored.
    v0 = vcount;
    @(posedge clk);
    #1 reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000005;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; req_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("reset_req_ignored", vcount == v0 && req_ready, 256'(vcount - v0), 256'(0));

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      ready_mode = $urandom_range(0, 2);
      w = ($urandom_range(0, 2) == 0);
      a = {6'd0, 2'($urandom_range(0, 3)), 8'd0, 3'd0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      for (int i = 0; i < 64; i++) d[32*i +: 32] = $urandom;
      do_req(w, a, d, e);
      wait_idle();
    end
    ready_mode = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
